// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types and constants for the register-file write scheduler.
package regfile_write_scheduler_pkg;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         WR_DATA_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PART  = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  // Write request as seen on any writeback source, at the default data width.
  typedef struct packed {
    logic                 valid;
    logic [4:0]           addr;
    logic [WR_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Bus bundle for the register-file write scheduler: ALU and load writeback
// requests, the single register-file write port, and the hazard lookup.
interface regfile_write_scheduler_if #(
  parameter int d_size = 32
);
  logic              alu_wr_valid;
  logic [4:0]        alu_wr_addr;
  logic [d_size-1:0] alu_wr_data;
  logic              alu_wr_ready;
  logic              ld_wr_valid;
  logic [4:0]        ld_wr_addr;
  logic [d_size-1:0] ld_wr_data;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [d_size-1:0] rf_wdata;
  logic [4:0]        q_rs;
  logic [4:0]        q_rt;
  logic              hz_rs;
  logic              hz_rt;
  logic [d_size-1:0] byp_rs;
  logic [d_size-1:0] byp_rt;
  logic [15:0]       conflict_cnt;

  modport master (
    output alu_wr_valid, alu_wr_addr, alu_wr_data, ld_wr_valid, ld_wr_addr,
           ld_wr_data, q_rs, q_rt,
    input  alu_wr_ready, rf_we, rf_waddr, rf_wdata, hz_rs, hz_rt, byp_rs,
           byp_rt, conflict_cnt
  );

  modport slave (
    input  alu_wr_valid, alu_wr_addr, alu_wr_data, ld_wr_valid, ld_wr_addr,
           ld_wr_data, q_rs, q_rt,
    output alu_wr_ready, rf_we, rf_waddr, rf_wdata, hz_rs, hz_rt, byp_rs,
           byp_rt, conflict_cnt
  );
endinterface

// File: rtl/regfile_ws_buffer.sv
// ALU-write holding FIFO with per-entry address invalidate and a
// youngest-match lookup for hazard/bypass queries.
module regfile_ws_buffer
  import regfile_write_scheduler_pkg::*;
#(
  parameter int d_size    = 32,
  parameter int buf_depth = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq,
  input  logic [4:0]        enq_addr,
  input  logic [d_size-1:0] enq_data,
  input  logic              deq,
  input  logic              inv_en,
  input  logic [4:0]        inv_addr,
  output logic              head_vld,
  output logic [4:0]        head_addr,
  output logic [d_size-1:0] head_data,
  output buf_state_e        state,
  input  logic [4:0]        q_rs,
  input  logic [4:0]        q_rt,
  output logic              hit_rs,
  output logic              hit_rt,
  output logic [d_size-1:0] dat_rs,
  output logic [d_size-1:0] dat_rt
);
  localparam int PW = (buf_depth > 1) ? $clog2(buf_depth) : 1;
  localparam int CW = $clog2(buf_depth + 1);

  logic [buf_depth-1:0] valid_q, valid_d;
  logic [4:0]           addr_q [buf_depth];
  logic [4:0]           addr_d [buf_depth];
  logic [d_size-1:0]    data_q [buf_depth];
  logic [d_size-1:0]    data_d [buf_depth];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  buf_state_e           state_q, state_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(buf_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  // Slot holding the entry 'off' positions younger than the head.
  function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input int off);
    int s;
    s = int'({1'b0, base}) + off;
    if (s >= buf_depth) s = s - buf_depth;
    return PW'(s);
  endfunction

  // Entry storage: invalidate on load match, retire head, append tail.
  always_comb begin
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    for (int i = 0; i < buf_depth; i++) begin
      if (inv_en && valid_q[i] && (addr_q[i] == inv_addr)) valid_d[i] = 1'b0;
    end
    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
    end
    if (enq) begin
      valid_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q]  = enq_addr;
      data_d[wr_ptr_q]  = enq_data;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
  end

  // Occupancy FSM: follows the net of enqueue minus dequeue.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (enq && !deq)      cnt_d = cnt_q + CW'(1);
    else if (!enq && deq) cnt_d = cnt_q - CW'(1);
    case (state_q)
      EMPTY: if (enq && !deq) state_d = (buf_depth == 1) ? FULL : PART;
      PART: begin
        if (enq && !deq && (cnt_q == CW'(buf_depth - 1)))  state_d = FULL;
        else if (!enq && deq && (cnt_q == CW'(1)))         state_d = EMPTY;
      end
      FULL:    if (!enq && deq) state_d = (buf_depth == 1) ? EMPTY : PART;
      default: state_d = EMPTY;
    endcase
  end

  // Control state with reset; entry payload is plain storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= EMPTY;
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  // Payload registers, written only through the enqueue path.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Youngest-match lookup: walk oldest to youngest, later hits override.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    dat_rs = '0;
    dat_rt = '0;
    for (int i = 0; i < buf_depth; i++) begin
      if (valid_q[slot(rd_ptr_q, i)] && (addr_q[slot(rd_ptr_q, i)] == q_rs) && (q_rs != REG_ZERO)) begin
        hit_rs = 1'b1;
        dat_rs = data_q[slot(rd_ptr_q, i)];
      end
      if (valid_q[slot(rd_ptr_q, i)] && (addr_q[slot(rd_ptr_q, i)] == q_rt) && (q_rt != REG_ZERO)) begin
        hit_rt = 1'b1;
        dat_rt = data_q[slot(rd_ptr_q, i)];
      end
    end
  end

  assign head_vld  = valid_q[rd_ptr_q];
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign state     = state_q;

endmodule

// File: rtl/regfile_write_scheduler.sv
// Register-file write scheduler: arbitrates load returns and ALU writebacks
// onto one registered write port, buffering ALU writes that lose arbitration.
// Optional feature macro: REGFILE_WS_BYPASS_EN (forward pending data on byp_*).
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int d_size    = 32,
  parameter int depth     = 32,
  parameter int buf_depth = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_write_scheduler_if.slave bus
);
  logic              alu_ready, ld_issue, alu_live, bypass, enq, deq, head_wr;
  logic              head_vld, buf_hit_rs, buf_hit_rt, rf_hit_rs, rf_hit_rt;
  logic [4:0]        head_addr;
  logic [d_size-1:0] head_data, buf_dat_rs, buf_dat_rt;
  buf_state_e        buf_state;

  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [d_size-1:0] rf_wdata_q, rf_wdata_d;
  logic [15:0]       conflict_q, conflict_d;

  // Writes to r0 or beyond the register file are accepted and discarded.
  function automatic logic reg_live(input logic [4:0] a);
    return (a != REG_ZERO) && (int'({27'd0, a}) < depth);
  endfunction

  // Arbitration: load first, then buffered head, then a direct ALU bypass.
  // An ALU write hitting the same register as a concurrent load loses to it.
  always_comb begin
    alu_ready = rst && (buf_state != FULL);
    ld_issue  = bus.ld_wr_valid && reg_live(bus.ld_wr_addr);
    alu_live  = bus.alu_wr_valid && alu_ready && reg_live(bus.alu_wr_addr)
                && !(ld_issue && (bus.alu_wr_addr == bus.ld_wr_addr));
    bypass    = alu_live && (buf_state == EMPTY) && !bus.ld_wr_valid;
    enq       = alu_live && !bypass;
    deq       = (buf_state != EMPTY) && (!head_vld || !ld_issue);
    head_wr   = deq && head_vld;
  end

  regfile_ws_buffer #(
    .d_size    (d_size),
    .buf_depth (buf_depth)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .enq       (enq),
    .enq_addr  (bus.alu_wr_addr),
    .enq_data  (bus.alu_wr_data),
    .deq       (deq),
    .inv_en    (ld_issue),
    .inv_addr  (bus.ld_wr_addr),
    .head_vld  (head_vld),
    .head_addr (head_addr),
    .head_data (head_data),
    .state     (buf_state),
    .q_rs      (bus.q_rs),
    .q_rt      (bus.q_rt),
    .hit_rs    (buf_hit_rs),
    .hit_rt    (buf_hit_rt),
    .dat_rs    (buf_dat_rs),
    .dat_rt    (buf_dat_rt)
  );

  // Next write-port contents and saturating conflict counter.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (ld_issue) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.ld_wr_addr;
      rf_wdata_d = bus.ld_wr_data;
    end else if (head_wr) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head_addr;
      rf_wdata_d = head_data;
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.alu_wr_addr;
      rf_wdata_d = bus.alu_wr_data;
    end
    conflict_d = conflict_q;
    if (bus.ld_wr_valid && bus.alu_wr_valid && (conflict_q != 16'hFFFF))
      conflict_d = conflict_q + 16'd1;
  end

  // Registered write port and counter; reset discards any pending write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      conflict_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      conflict_q <= conflict_d;
    end
  end

  // Hazard flags and forwarding; the write-port stage counts as youngest.
  always_comb begin
    rf_hit_rs = rf_we_q && (rf_waddr_q == bus.q_rs) && (bus.q_rs != REG_ZERO);
    rf_hit_rt = rf_we_q && (rf_waddr_q == bus.q_rt) && (bus.q_rt != REG_ZERO);
    bus.hz_rs = rst && (rf_hit_rs || buf_hit_rs);
    bus.hz_rt = rst && (rf_hit_rt || buf_hit_rt);
`ifdef REGFILE_WS_BYPASS_EN
    bus.byp_rs = '0;
    bus.byp_rt = '0;
    if (rst) begin
      if (rf_hit_rs)       bus.byp_rs = rf_wdata_q;
      else if (buf_hit_rs) bus.byp_rs = buf_dat_rs;
      if (rf_hit_rt)       bus.byp_rt = rf_wdata_q;
      else if (buf_hit_rt) bus.byp_rt = buf_dat_rt;
    end
`else
    bus.byp_rs = '0;
    bus.byp_rt = '0;
`endif
  end

`ifndef REGFILE_WS_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{buf_dat_rs, buf_dat_rt};
`endif

  assign bus.alu_wr_ready = alu_ready;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.conflict_cnt = conflict_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench for regfile_write_scheduler: directed writeback scenarios
// queue expected register-file writes; a negedge monitor retires them.
module tb_regfile_write_scheduler;
  import regfile_write_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_write_scheduler_if #(.d_size(32)) bus ();

  regfile_write_scheduler #(
    .d_size    (32),
    .depth     (32),
    .buf_depth (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    wr_req_t req;
    int      cyc;  // expected cycle of rf_we, or -1 when only order matters
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input logic [4:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.req.valid = 1'b1;
    e.req.addr  = a;
    e.req.data  = d;
    e.cyc       = c;
    expq.push_back(e);
  endfunction

  function automatic logic [31:0] byp_exp(input logic [31:0] d);
`ifdef REGFILE_WS_BYPASS_EN
    return d;
`else
    return 32'd0 & d;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_wr_valid = 1'b0;
    bus.alu_wr_addr  = 5'd0;
    bus.alu_wr_data  = 32'd0;
    bus.ld_wr_valid  = 1'b0;
    bus.ld_wr_addr   = 5'd0;
    bus.ld_wr_data   = 32'd0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    bus.alu_wr_valid = 1'b1;
    bus.alu_wr_addr  = a;
    bus.alu_wr_data  = d;
  endtask

  task automatic ld(input logic [4:0] a, input logic [31:0] d);
    bus.ld_wr_valid = 1'b1;
    bus.ld_wr_addr  = a;
    bus.ld_wr_data  = d;
  endtask

  // Monitor: every write on the port must match the oldest expected write.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.rf_we === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL rf_unexpected got addr=%0d data=%h cyc=%0d want none",
                 bus.rf_waddr, bus.rf_wdata, cyc);
      end else begin
        e = expq.pop_front();
        if ((bus.rf_waddr !== e.req.addr) || (bus.rf_wdata !== e.req.data) ||
            ((e.cyc >= 0) && (cyc != e.cyc))) begin
          errors++;
          $display("FAIL rf_write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                   bus.rf_waddr, bus.rf_wdata, cyc, e.req.addr, e.req.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    idle();
    bus.q_rs = 5'd1;
    bus.q_rt = 5'd2;
    repeat (3) tick();
    #1;
    chk("rst_rf_we",    {31'd0, bus.rf_we},        32'd0);
    chk("rst_waddr",    {27'd0, bus.rf_waddr},     32'd0);
    chk("rst_wdata",    bus.rf_wdata,              32'd0);
    chk("rst_ready",    {31'd0, bus.alu_wr_ready}, 32'd0);
    chk("rst_conflict", {16'd0, bus.conflict_cnt}, 32'd0);
    chk("rst_hz_rs",    {31'd0, bus.hz_rs},        32'd0);
    chk("rst_byp_rs",   bus.byp_rs,                32'd0);
    rst = 1'b1;
    #1;
    chk("ready_release", {31'd0, bus.alu_wr_ready}, 32'd1);
    tick();

    // ALU-only stream, direct bypass with one cycle of latency.
    alu(5'd1, 32'h5); push(5'd1, 32'h5, cyc + 1); #1;
    chk("a_ready0", {31'd0, bus.alu_wr_ready}, 32'd1);
    tick();
    alu(5'd2, 32'h6); push(5'd2, 32'h6, cyc + 1); #1;
    chk("a_ready1", {31'd0, bus.alu_wr_ready}, 32'd1);
    tick();
    idle(); tick(); tick();

    // Load and ALU together: load first, ALU from the buffer next cycle.
    ld(5'd5, 32'h41); alu(5'd6, 32'h8);
    push(5'd5, 32'h41, cyc + 1); push(5'd6, 32'h8, cyc + 2);
    tick();
    idle(); tick(); tick();
    chk("b_conflict", {16'd0, bus.conflict_cnt}, 32'd1);

    // Three loads against three ALU writes: buffer fills, then drains in order.
    ld(5'd10, 32'hA1); alu(5'd7, 32'h71); push(5'd10, 32'hA1, cyc + 1); #1;
    chk("c_ready0", {31'd0, bus.alu_wr_ready}, 32'd1);
    tick();
    ld(5'd11, 32'hA2); alu(5'd8, 32'h81); push(5'd11, 32'hA2, cyc + 1); #1;
    chk("c_ready1", {31'd0, bus.alu_wr_ready}, 32'd1);
    tick();
    ld(5'd12, 32'hA3); alu(5'd9, 32'h91); push(5'd12, 32'hA3, cyc + 1); #1;
    chk("c_ready_full", {31'd0, bus.alu_wr_ready}, 32'd0);
    tick();
    bus.ld_wr_valid = 1'b0; push(5'd7, 32'h71, cyc + 1); #1;
    chk("c_ready_full_deq", {31'd0, bus.alu_wr_ready}, 32'd0);
    tick();
    push(5'd8, 32'h81, cyc + 1); #1;
    chk("c_ready_after", {31'd0, bus.alu_wr_ready}, 32'd1);
    tick();
    idle(); push(5'd9, 32'h91, cyc + 1);
    tick(); tick();
    chk("c_conflict", {16'd0, bus.conflict_cnt}, 32'd4);

    // Buffered ALU write to r4 superseded by a later load to r4.
    bus.q_rs = 5'd4; bus.q_rt = 5'd3;
    ld(5'd3, 32'h33); alu(5'd4, 32'h9); push(5'd3, 32'h33, cyc + 1);
    tick();
    idle(); ld(5'd4, 32'hB); push(5'd4, 32'hB, cyc + 1); #1;
    chk("d_hz_buffered", {31'd0, bus.hz_rs}, 32'd1);
    chk("d_byp_buffered", bus.byp_rs, byp_exp(32'h9));
    chk("d_hz_rt_stage", {31'd0, bus.hz_rt}, 32'd1);
    chk("d_byp_rt_stage", bus.byp_rt, byp_exp(32'h33));
    tick();
    idle(); #1;
    chk("d_hz_rf_stage", {31'd0, bus.hz_rs}, 32'd1);
    chk("d_byp_rf_stage", bus.byp_rs, byp_exp(32'hB));
    tick();
    #1;
    chk("d_hz_cleared", {31'd0, bus.hz_rs}, 32'd0);
    tick(); tick();

    // Writes to r0 from both sources are dropped without flags.
    bus.q_rs = 5'd0; bus.q_rt = 5'd0;
    alu(5'd0, 32'h77); #1;
    chk("e_ready", {31'd0, bus.alu_wr_ready}, 32'd1);
    tick();
    idle(); ld(5'd0, 32'h88); #1;
    chk("e_hz_rs0", {31'd0, bus.hz_rs}, 32'd0);
    tick();
    alu(5'd0, 32'h99); ld(5'd0, 32'hAA); #1;
    chk("e_hz_rs1", {31'd0, bus.hz_rs}, 32'd0);
    tick();
    idle(); #1;
    chk("e_hz_rt", {31'd0, bus.hz_rt}, 32'd0);
    alu(5'd13, 32'hDD); push(5'd13, 32'hDD, cyc + 1);
    tick();
    idle(); tick(); tick();
    chk("e_conflict", {16'd0, bus.conflict_cnt}, 32'd6);

    // Reset with two ALU writes still buffered: both are discarded.
    ld(5'd20, 32'hC1); alu(5'd21, 32'hD1); push(5'd20, 32'hC1, cyc + 1);
    tick();
    ld(5'd22, 32'hC2); alu(5'd23, 32'hD2); push(5'd22, 32'hC2, cyc + 1);
    tick();
    idle(); bus.q_rs = 5'd21; #1;
    chk("f_conflict_pre", {16'd0, bus.conflict_cnt}, 32'd8);
    rst = 1'b0; #1;
    chk("f_ready_in_rst", {31'd0, bus.alu_wr_ready}, 32'd0);
    chk("f_hz_in_rst", {31'd0, bus.hz_rs}, 32'd0);
    tick();
    #1;
    chk("f_rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("f_conflict", {16'd0, bus.conflict_cnt}, 32'd0);
    chk("f_ready", {31'd0, bus.alu_wr_ready}, 32'd0);
    tick();
    rst = 1'b1; #1;
    chk("f_ready_release", {31'd0, bus.alu_wr_ready}, 32'd1);
    chk("f_hz_release", {31'd0, bus.hz_rs}, 32'd0);
    repeat (4) tick();

    chk("drain_empty", expq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

Interface
REQ-001 Parameter d_size, default 32, register data width in bits.
REQ-002 Parameter depth, default 32, number of architectural registers; address width is 5 bits.
REQ-003 Parameter buf_depth, default 2, number of ALU-write holding slots.
REQ-004 The module SHALL have one clock and a synchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock, sole clock of the block.
REQ-006 rst  in  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-007 alu_wr_valid, alu_wr_addr, alu_wr_data  in  1/5/d_size  ALU writeback request.
REQ-008 alu_wr_ready  out  1  ALU request accepted this cycle.
REQ-009 ld_wr_valid, ld_wr_addr, ld_wr_data  in  1/5/d_size  load-return writeback request; always accepted.
REQ-010 rf_we, rf_waddr, rf_wdata  out  1/5/d_size  single register-file write port.
REQ-011 q_rs, q_rt  in  5/5  source addresses to check against pending writes.
REQ-012 hz_rs, hz_rt  out  1/1  source has a buffered, unwritten write.
REQ-013 byp_rs, byp_rt  out  d_size  youngest buffered data for q_rs/q_rt.
REQ-014 conflict_cnt  out  16  count of cycles where both requesters were valid.

Function
REQ-015 Per cycle, at most one write SHALL issue on the rf_* port, with priority load > oldest buffered ALU entry > incoming ALU request.
REQ-016 rf_* SHALL be registered, giving 1-cycle latency from request acceptance to rf_we.
REQ-017 An incoming ALU request SHALL bypass the buffer only when the buffer is empty and ld_wr_valid=0.
REQ-018 Otherwise an accepted ALU request SHALL be enqueued at the buffer tail, preserving FIFO order.
REQ-019 alu_wr_ready SHALL be 1 unless the buffer is full; if the buffer is full and a dequeue occurs in the same cycle, ready SHALL still be 0.
REQ-020 The buffer FSM states SHALL be EMPTY, PART, and FULL, moving on the net change of enqueue minus dequeue; a simultaneous enqueue and dequeue SHALL hold the state.
REQ-021 A write with address 0, from either source, SHALL be accepted and dropped: no rf_we and no buffer entry.
REQ-022 When a load issues, every buffered entry with the same address SHALL be invalidated, because the load is treated as youngest; invalidated entries SHALL be dequeued without rf_we.
REQ-023 hz_rs/hz_rt SHALL be combinational from the valid buffer entries plus the registered rf_* stage; address 0 SHALL never flag.
REQ-024 conflict_cnt SHALL increment when ld_wr_valid and alu_wr_valid are both 1, and SHALL saturate at 16'hFFFF.
REQ-025 Buffer pointers SHALL wrap modulo buf_depth.

Reset
REQ-026 With rst=0 at a clock edge, the block SHALL produce rf_we=0, rf_waddr=0, rf_wdata=0, an empty buffer (all entries invalid), state EMPTY, and conflict_cnt=0.
REQ-027 While rst=0, alu_wr_ready, hz_rs, hz_rt, byp_rs, and byp_rt SHALL all be 0.
REQ-028 Reset during pending writes SHALL discard them with no rf_we.

Configuration
REQ-029 Macro REGFILE_WS_BYPASS_EN defined: byp_rs/byp_rt SHALL carry the youngest matching pending data, with the rf_* stage counting as youngest.
REQ-030 Macro REGFILE_WS_BYPASS_EN undefined: byp_rs/byp_rt SHALL be tied to 0; hz_* remain active and consumers stall instead.

Structure
REQ-031 A shared package SHALL hold the FSM state typedef (EMPTY/PART/FULL), the write-request struct (valid, addr, data), and the constant REG_ZERO=5'd0.
REQ-032 One sub-module SHALL exist: regfile_ws_buffer, the FIFO with per-entry address-match invalidate and lookup.

Verification
REQ-033 ALU-only stream of 0x5 to r1 then 0x6 to r2: rf_we on cycles N+1 and N+2 with matching data; alu_wr_ready stays 1.
REQ-034 Load 0x41 to r5 and ALU 0x8 to r6 in the same cycle: r5 is written first, r6 the next cycle; conflict_cnt=1.
REQ-035 Three loads back-to-back while ALU writes r7, r8, r9: the buffer fills, alu_wr_ready=0 on the third ALU request, and after the loads the drain order is r7, r8, r9.
REQ-036 ALU 0x9 to r4 buffered, then load 0xB to r4: only 0xB is written to r4, and hz_rs for q_rs=4 clears after the load write.
REQ-037 Writes to r0 from either source: no rf_we, and hz_* stays 0 for q_rs=0.
REQ-038 Assert rst=0 with two entries buffered: the next cycle shows rf_we=0, alu_wr_ready=0, and conflict_cnt=0; after release, alu_wr_ready=1.
